// File: rtl/counter_mod_updown_shift_param.sv
// Parametrised modulo up/down counter with shift/rotate modes, programmable
// wrap limit W, optional saturation and single-cycle overflow/underflow pulses.
module counter_mod_updown_shift_param #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] W,
  input  logic             L,
  input  logic             INC,
  input  logic             DEC,
  input  logic             SHL,
  input  logic             SHR,
  input  logic             SAT,
  input  logic             ROT,
  output logic [WIDTH-1:0] Q,
  output logic             OVF,
  output logic             UNF,
  output logic             Z,
  output logic             M
);

  logic [WIDTH-1:0] q_next;
  logic             ovf_next;
  logic             unf_next;
  logic             shl_in;
  logic             shr_in;

  assign shl_in = ROT ? Q[WIDTH-1] : D[0];
  assign shr_in = ROT ? Q[0]       : D[WIDTH-1];

  // Exactly one action per edge, by priority; flags default low so they pulse.
  always_comb begin
    q_next   = Q;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (L) begin
      q_next = D;
    end else if (INC) begin
      if (Q < W) begin
        q_next = Q + 1'b1;
      end else begin
        q_next   = SAT ? W : '0;
        ovf_next = 1'b1;
      end
    end else if (DEC) begin
      if (Q > W) begin
        // Out-of-range value (from a load or a shrinking W) clamps back in.
        q_next = W;
      end else if (Q != '0) begin
        q_next = Q - 1'b1;
      end else begin
        q_next   = SAT ? '0 : W;
        unf_next = 1'b1;
      end
    end else if (SHL) begin
      q_next = {Q[WIDTH-2:0], shl_in};
    end else if (SHR) begin
      q_next = {shr_in, Q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      Q   <= RESET_VAL;
      OVF <= 1'b0;
      UNF <= 1'b0;
    end else begin
      Q   <= q_next;
      OVF <= ovf_next;
      UNF <= unf_next;
    end
  end

  assign Z = (Q == '0);
  assign M = (Q == W);

endmodule

// File: tb/tb_counter_mod_updown_shift_param.sv
// Bench for counter_mod_updown_shift_param: a 4-bit and an 8-bit instance,
// each tracked every cycle by an arithmetic reference model plus literal checks.
module tb_counter_mod_updown_shift_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 4-bit instance
  logic       r4 = 1'b1, l4 = 1'b0, inc4 = 1'b0, dec4 = 1'b0, shl4 = 1'b0, shr4 = 1'b0;
  logic       sat4 = 1'b0, rot4 = 1'b0;
  logic [3:0] d4 = '0, w4 = '0;
  logic [3:0] q4;
  logic       ovf4, unf4, z4, m4;

  // 8-bit instance with a nonzero reset value
  localparam int RV8 = 8'h3C;
  logic       r8 = 1'b1, l8 = 1'b0, inc8 = 1'b0, dec8 = 1'b0, shl8 = 1'b0, shr8 = 1'b0;
  logic       sat8 = 1'b0, rot8 = 1'b0;
  logic [7:0] d8 = '0, w8 = '0;
  logic [7:0] q8;
  logic       ovf8, unf8, z8, m8;

  counter_mod_updown_shift_param #(.WIDTH(4), .RESET_VAL(4'd0)) dut4 (
    .C(clk), .R(r4), .D(d4), .W(w4), .L(l4), .INC(inc4), .DEC(dec4),
    .SHL(shl4), .SHR(shr4), .SAT(sat4), .ROT(rot4),
    .Q(q4), .OVF(ovf4), .UNF(unf4), .Z(z4), .M(m4));

  counter_mod_updown_shift_param #(.WIDTH(8), .RESET_VAL(8'h3C)) dut8 (
    .C(clk), .R(r8), .D(d8), .W(w8), .L(l8), .INC(inc8), .DEC(dec8),
    .SHL(shl8), .SHR(shr8), .SAT(sat8), .ROT(rot8),
    .Q(q8), .OVF(ovf8), .UNF(unf8), .Z(z8), .M(m8));

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference behaviour written directly from the operation rules on integers.
  function automatic void model_step(
    input int width, input int q, input int d, input int w, input int rv,
    input bit r, input bit l, input bit inc, input bit dec,
    input bit shl, input bit shr, input bit sat, input bit rot,
    output int nq, output bit novf, output bit nunf);
    int top;
    int s;
    top  = (1 << width) - 1;
    novf = 0;
    nunf = 0;
    nq   = q;
    if (r)        nq = rv;
    else if (l)   nq = d;
    else if (inc) begin
      if (q < w) nq = q + 1;
      else begin nq = sat ? w : 0; novf = 1; end
    end else if (dec) begin
      if (q > w)      nq = w;
      else if (q > 0) nq = q - 1;
      else begin nq = sat ? 0 : w; nunf = 1; end
    end else if (shl) begin
      s  = rot ? ((q >> (width - 1)) & 1) : (d & 1);
      nq = ((q * 2) & top) | s;
    end else if (shr) begin
      s  = rot ? (q & 1) : ((d >> (width - 1)) & 1);
      nq = (q / 2) + s * (1 << (width - 1));
    end
  endfunction

  int mq4 = 0, mq8 = 0;
  bit mo4 = 0, mu4 = 0, mo8 = 0, mu8 = 0;
  bit valid4 = 0, valid8 = 0;

  // Single compare process: advance both models on each edge, check just after.
  initial begin
    forever begin
      @(posedge clk);
      model_step(4, mq4, int'(d4), int'(w4), 0, r4, l4, inc4, dec4, shl4, shr4,
                 sat4, rot4, mq4, mo4, mu4);
      model_step(8, mq8, int'(d8), int'(w8), RV8, r8, l8, inc8, dec8, shl8, shr8,
                 sat8, rot8, mq8, mo8, mu8);
      if (r4) valid4 = 1;
      if (r8) valid8 = 1;
      #1;
      if (valid4) begin
        chk("q4", int'(q4), mq4);
        chk("ovf4", int'(ovf4), int'(mo4));
        chk("unf4", int'(unf4), int'(mu4));
        chk("z4", int'(z4), int'(mq4 == 0));
        chk("m4", int'(m4), int'(mq4 == int'(w4)));
      end
      if (valid8) begin
        chk("q8", int'(q8), mq8);
        chk("ovf8", int'(ovf8), int'(mo8));
        chk("unf8", int'(unf8), int'(mu8));
        chk("z8", int'(z8), int'(mq8 == 0));
        chk("m8", int'(m8), int'(mq8 == int'(w8)));
      end
    end
  end

  // ops = {R, L, INC, DEC, SHL, SHR}; returns 2 time units after the edge.
  task automatic op4(input logic [5:0] ops, input logic [3:0] d);
    {r4, l4, inc4, dec4, shl4, shr4} = ops;
    d4 = d;
    @(posedge clk);
    #2;
  endtask

  task automatic op8(input logic [5:0] ops, input logic [7:0] d);
    {r8, l8, inc8, dec8, shl8, shr8} = ops;
    d8 = d;
    @(posedge clk);
    #2;
  endtask

  localparam logic [5:0] NOP = 6'b000000, RST = 6'b100000, LD = 6'b010000,
                         INC = 6'b001000, DEC = 6'b000100, SL = 6'b000010,
                         SR = 6'b000001;

  initial begin
    // Both instances reset on the first edge; the 4-bit one with a load pending.
    op4(RST | LD, 4'd9);
    r8 = 1'b0;
    chk("rst_q", int'(q4), 0);
    chk("rst_z", int'(z4), 1);
    chk("rst_ovf", int'(ovf4), 0);
    chk("rst_q8", int'(q8), 8'h3C);
    for (int i = 0; i < 3; i++) op4(NOP, 4'd0);
    chk("hold_q", int'(q4), 0);

    // Wrap up
    w4 = 4'd5; sat4 = 1'b0;
    op4(LD, 4'd3);
    op4(INC, 0); chk("wrap_q1", int'(q4), 4); chk("wrap_ovf1", int'(ovf4), 0);
    op4(INC, 0); chk("wrap_q2", int'(q4), 5); chk("wrap_m2", int'(m4), 1);
    op4(INC, 0); chk("wrap_q3", int'(q4), 0); chk("wrap_ovf3", int'(ovf4), 1);
    op4(INC, 0); chk("wrap_q4", int'(q4), 1); chk("wrap_ovf4", int'(ovf4), 0);

    // Saturate and underflow
    sat4 = 1'b1;
    op4(LD, 4'd5);
    op4(INC, 0); chk("sat_q", int'(q4), 5); chk("sat_ovf", int'(ovf4), 1);
    op4(LD, 4'd1);
    op4(DEC, 0); chk("sdec_q1", int'(q4), 0); chk("sdec_unf1", int'(unf4), 0);
    op4(DEC, 0); chk("sdec_q2", int'(q4), 0); chk("sdec_unf2", int'(unf4), 1);
    sat4 = 1'b0;
    op4(LD, 4'd1);
    op4(DEC, 0); chk("wdec_q1", int'(q4), 0);
    op4(DEC, 0); chk("wdec_q2", int'(q4), 5); chk("wdec_unf2", int'(unf4), 1);

    // Out-of-range and priority
    op4(LD, 4'd12);
    op4(DEC, 0); chk("oor_dec_q", int'(q4), 5); chk("oor_dec_unf", int'(unf4), 0);
    op4(LD, 4'd12);
    op4(INC, 0); chk("oor_inc_q", int'(q4), 0); chk("oor_inc_ovf", int'(ovf4), 1);
    op4(LD | INC | DEC, 4'd7);
    chk("prio_q", int'(q4), 7); chk("prio_ovf", int'(ovf4), 0);
    chk("prio_unf", int'(unf4), 0);

    // Shifts from 1001
    rot4 = 1'b0; op4(LD, 4'b1001); op4(SL, 4'b0000); chk("shl_d", int'(q4), 4'b0010);
    rot4 = 1'b1; op4(LD, 4'b1001); op4(SL, 4'b0000); chk("shl_rot", int'(q4), 4'b0011);
    op4(LD, 4'b1001); op4(SR, 4'b0000); chk("shr_rot", int'(q4), 4'b1100);
    rot4 = 1'b0; op4(LD, 4'b1001); op4(SR, 4'b0000); chk("shr_d", int'(q4), 4'b0100);
    op4(SR, 4'b1000); chk("shr_d1", int'(q4), 4'b1010);
    op4(SL | SR, 4'b0001); chk("shl_d1", int'(q4), 4'b0101);

    // Mixed traffic with changing W, checked by the model only
    for (int i = 0; i < 80; i++) begin
      w4   = 4'($urandom_range(0, 15));
      sat4 = 1'($urandom_range(0, 1));
      rot4 = 1'($urandom_range(0, 1));
      op4(6'($urandom_range(0, 63)) & (($urandom_range(0, 7) == 0) ? 6'h3F : 6'h1F),
          4'($urandom_range(0, 15)));
    end
    op4(NOP, 0);

    // 8-bit: W = 0
    w8 = 8'd0; sat8 = 1'b0;
    op8(INC, 0); chk("w0_q1", int'(q8), 0); chk("w0_ovf1", int'(ovf8), 1);
    op8(INC, 0); chk("w0_ovf2", int'(ovf8), 1);
    op8(INC, 0); chk("w0_q3", int'(q8), 0); chk("w0_ovf3", int'(ovf8), 1);
    op8(LD, 8'd7);
    op8(DEC, 0); chk("w0_clamp_q", int'(q8), 0); chk("w0_clamp_unf", int'(unf8), 0);
    op8(DEC, 0); chk("w0_dec_q", int'(q8), 0); chk("w0_dec_unf", int'(unf8), 1);

    // 8-bit: W = 255
    w8 = 8'd255;
    op8(LD, 8'd255); chk("wmax_m", int'(m8), 1);
    op8(INC, 0); chk("wmax_inc_q", int'(q8), 0); chk("wmax_inc_ovf", int'(ovf8), 1);
    op8(DEC, 0); chk("wmax_dec_q", int'(q8), 255); chk("wmax_dec_unf", int'(unf8), 1);
    op8(RST | INC, 0); chk("rst8_q", int'(q8), 8'h3C); chk("rst8_ovf", int'(ovf8), 0);
    op8(NOP, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_mod_updown_shift_param.md
# counter_mod_updown_shift_param

Parametrised up/down counter with shift register modes and a programmable wrap limit. It extends the fixed 4-bit inc/dec/shift counter family to any width, adds synchronous reset, a saturate mode, a rotate mode, and overflow/underflow event pulses. It sits in datapath and control blocks as a general-purpose modulo counter, index pointer or shift stage. All state changes on the rising clock edge.

## Interface
- WIDTH, 8, counter and data width in bits (≥2)
- RESET_VAL, 0, value loaded into Q on reset (WIDTH bits)

- C  in  1  clock, rising edge active
- R  in  1  reset, synchronous, active-high
- D  in  WIDTH  parallel load data; D[0] is the SHL serial-in, D[WIDTH-1] is the SHR serial-in
- W  in  WIDTH  wrap limit; counting range is 0..W inclusive
- L  in  1  parallel load
- INC  in  1  increment
- DEC  in  1  decrement
- SHL  in  1  shift left
- SHR  in  1  shift right
- SAT  in  1  1 = saturate at range ends, 0 = wrap
- ROT  in  1  1 = shifts rotate, 0 = shifts take serial-in from D
- Q  out  WIDTH  counter value, registered
- OVF  out  1  registered pulse: INC hit the upper bound
- UNF  out  1  registered pulse: DEC hit the lower bound
- Z  out  1  combinational, Q == 0
- M  out  1  combinational, Q == W

## Operation
- Priority per edge: R > L > INC > DEC > SHL > SHR. Exactly one action is taken. Lower-priority requests in the same cycle are ignored, not queued.
- R: Q ← RESET_VAL, OVF ← 0, UNF ← 0.
- L: Q ← D. W is not checked, so a loaded value may exceed W.
- INC:
  - Q < W: Q ← Q+1.
  - Q ≥ W: Q ← 0 if SAT=0, Q ← W if SAT=1. OVF ← 1 in both cases.
- DEC:
  - Q > W: Q ← W (clamp back into range), no flag.
  - 0 < Q ≤ W: Q ← Q−1.
  - Q == 0: Q ← W if SAT=0, Q ← 0 if SAT=1. UNF ← 1 in both cases.
- SHL: Q ← {Q[WIDTH-2:0], s}, where s = Q[WIDTH-1] if ROT=1, else D[0].
- SHR: Q ← {s, Q[WIDTH-1:1]}, where s = Q[0] if ROT=1, else D[WIDTH-1].
- Shifts ignore W. Shifts never raise OVF or UNF.
- No request asserted: Q holds.
- OVF and UNF are cleared on every edge on which their own condition is not met. Each is therefore a single-cycle pulse per event. Consecutive events produce OVF/UNF high on consecutive cycles.
- Arithmetic is unsigned, modulo 2^WIDTH internally. Comparisons against W are unsigned and full-width.
- W == 0:
  - INC always yields Q=0 with OVF=1.
  - DEC from 0 yields 0 with UNF=1.
  - DEC from a nonzero value yields 0 (clamp), no flag.
- W == 2^WIDTH−1: the counter behaves as a plain full-range counter.
- W may change on any cycle. It takes effect on the next edge. Z and M track the current Q and W combinationally.

## Timing
- Latency: one edge from request to Q, OVF and UNF update. No multi-cycle operations and no internal state beyond Q, OVF and UNF.
- Reset is synchronous. It takes effect on the first rising edge with R=1 and overrides any request in progress. After reset: Q=RESET_VAL, OVF=0, UNF=0, Z=(RESET_VAL==0), M=(RESET_VAL==W).
- Releasing R: the request present on the first edge with R=0 executes normally.
- Inputs must meet setup/hold to C. There is no input registering.

## Test plan
WIDTH=4 unless stated.
- Reset and hold: R=1 with L=1, D=9 for one edge → Q=0, OVF=0, UNF=0, Z=1. Then R=0 with no request for 3 edges → Q stays 0.
- Wrap up: W=5, SAT=0, load 3, then INC ×4 → Q=4,5,0,1. OVF is high only in the cycle Q=0. M is high while Q=5.
- Saturate and underflow: W=5, SAT=1, Q=5.
  - INC → Q=5, OVF=1.
  - Load 1, DEC ×2 → Q=0 then 0, with UNF=1 on the second edge only.
  - Repeat with SAT=0 → second DEC gives Q=5, UNF=1.
- Out-of-range and priority:
  - W=5, load 12, then DEC → Q=5, no flag.
  - Load 12, then INC → Q=0, OVF=1.
  - L=INC=DEC=1 with D=7 → Q=7, no flags.
- Shifts: Q=4'b1001.
  - SHL with ROT=0, D[0]=0 → 0010.
  - SHL with ROT=1 → 0011 (from 1001).
  - SHR with ROT=1 from 1001 → 1100.
  - SHR with ROT=0, D[3]=0 from 1001 → 0100.
  - OVF and UNF stay 0 throughout.
- WIDTH=8, W=0 and W=255:
  - W=0: INC ×3 → Q=0 with OVF high for 3 consecutive cycles.
  - W=255, Q=255: INC → Q=0, OVF=1. DEC → Q=255, UNF=1.
